mem_port_arbiter: RTL and testbench

Shares one single-port main memory between two requesters: the instruction-fetch port (IF) and the load/store port (MEM stage, LS). A request/grant/valid handshake serialises accesses and holds the RAM address, data and enables stable for RAM_LAT cycles. LS normally has priority, and a starvation counter guarantees IF forward progress. Per-port stall outputs drive the pipeline registers, replacing the fixed single-cycle memory assumption.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_starve_ctr.sv | 31 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and access owner.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive contested LS wins; raises force_if_o once IF has lost STARVE_MAX times.
module arb_starve_ctr #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic contested_i,
   input  logic if_win_i,
   output logic force_if_o
);

   localparam int unsigned CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (if_win_i)
         cnt_d = '0;
      else if (contested_i && (cnt_q != CW'(STARVE_MAX)))
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign force_if_o = (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and LS loads/stores onto one single-port RAM, holding the
// RAM controls stable for RAM_LAT cycles, with LS priority and IF starvation relief.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned RAM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_rvalid,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_rvalid,
   output logic [ADDR_W-1:0] ram_location,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_re,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   localparam int unsigned LW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [LW-1:0]     lat_q, lat_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

   logic in_idle, win_if, force_if;

   assign in_idle = (state_q == IDLE);
   // LS has priority unless the starvation counter has saturated.
   assign win_if  = if_req & (~ls_req | force_if);

   arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
      .clk         (clk),
      .reset       (reset),
      .contested_i (in_idle & if_req & ls_req),
      .if_win_i    (in_idle & win_if),
      .force_if_o  (force_if)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      lat_d      = lat_q;
      if_rdata_d = if_rdata_q;
      ls_rdata_d = ls_rdata_q;
      case (state_q)
         IDLE: begin
            if (if_req || ls_req) begin
               state_d = ACCESS;
               owner_d = win_if ? OWN_IF : OWN_LS;
               addr_d  = win_if ? if_addr : ls_addr;
               we_d    = ~win_if & ls_we;
               wdata_d = win_if ? '0 : ls_wdata;
               lat_d   = LW'(RAM_LAT - 1);
            end
         end
         ACCESS: begin
            if (lat_q == '0) begin
               state_d = RESP;
               if (!we_q) begin
                  if (owner_q == OWN_IF) if_rdata_d = ram_rdata;
                  else                   ls_rdata_d = ram_rdata;
               end
            end else begin
               lat_d = lat_q - LW'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         lat_q      <= '0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         lat_q      <= lat_d;
         if_rdata_q <= if_rdata_d;
         ls_rdata_q <= ls_rdata_d;
      end
   end

   logic in_access, first_access;
   assign in_access    = (state_q == ACCESS);
   // The latency counter is still at its load value only in the first ACCESS cycle.
   assign first_access = in_access && (lat_q == LW'(RAM_LAT - 1));

   assign if_gnt       = first_access && (owner_q == OWN_IF);
   assign ls_gnt       = first_access && (owner_q == OWN_LS);
   assign if_rvalid    = (state_q == RESP) && (owner_q == OWN_IF);
   assign ls_rvalid    = (state_q == RESP) && (owner_q == OWN_LS);
   assign ram_re       = in_access & ~we_q;
   assign ram_we       = in_access & we_q;
   assign ram_location = addr_q;
   assign ram_wdata    = wdata_q;
   assign if_rdata     = if_rdata_q;
   assign ls_rdata     = ls_rdata_q;
   assign stall_if     = if_req & ~if_rvalid;
   assign stall_mem    = ls_req & ~ls_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter with RAM_LAT=1 (A) and one with RAM_LAT=3 (B); rvalid responses
// are checked against per-DUT expectation queues by independent monitors.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, if_req_a, ls_req_a, ls_we_a;
   logic [31:0] if_addr_a, ls_addr_a, ls_wdata_a, rdata_a;
   logic        if_gnt_a, if_rvalid_a, ls_gnt_a, ls_rvalid_a, re_a, we_a, stall_if_a, stall_mem_a;
   logic [31:0] if_rdata_a, ls_rdata_a, loc_a, wdata_a;

   logic        rst_b, if_req_b, ls_req_b, ls_we_b;
   logic [31:0] if_addr_b, ls_addr_b, ls_wdata_b, rdata_b;
   logic        if_gnt_b, if_rvalid_b, ls_gnt_b, ls_rvalid_b, re_b, we_b, stall_if_b, stall_mem_b;
   logic [31:0] if_rdata_b, ls_rdata_b, loc_b, wdata_b;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1), .STARVE_MAX(4)) u_dut_a (
      .clk(clk), .reset(rst_a),
      .if_req(if_req_a), .if_addr(if_addr_a), .if_gnt(if_gnt_a), .if_rdata(if_rdata_a),
      .if_rvalid(if_rvalid_a), .ls_req(ls_req_a), .ls_we(ls_we_a), .ls_addr(ls_addr_a),
      .ls_wdata(ls_wdata_a), .ls_gnt(ls_gnt_a), .ls_rdata(ls_rdata_a), .ls_rvalid(ls_rvalid_a),
      .ram_location(loc_a), .ram_wdata(wdata_a), .ram_re(re_a), .ram_we(we_a),
      .ram_rdata(rdata_a), .stall_if(stall_if_a), .stall_mem(stall_mem_a)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3), .STARVE_MAX(4)) u_dut_b (
      .clk(clk), .reset(rst_b),
      .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b), .if_rdata(if_rdata_b),
      .if_rvalid(if_rvalid_b), .ls_req(ls_req_b), .ls_we(ls_we_b), .ls_addr(ls_addr_b),
      .ls_wdata(ls_wdata_b), .ls_gnt(ls_gnt_b), .ls_rdata(ls_rdata_b), .ls_rvalid(ls_rvalid_b),
      .ram_location(loc_b), .ram_wdata(wdata_b), .ram_re(re_b), .ram_we(we_b),
      .ram_rdata(rdata_b), .stall_if(stall_if_b), .stall_mem(stall_mem_b)
   );

   function automatic logic [31:0] model(input logic [31:0] a);
      case (a)
         32'h10:  return 32'h0050_0093;
         32'h14:  return 32'h1234_5678;
         32'h200: return 32'hCAFE_F00D;
         default: return a ^ 32'hA5A5_0000;
      endcase
   endfunction

   // RAM A answers immediately; RAM B only presents real data in the 3rd enabled cycle.
   assign rdata_a = model(loc_a);
   int re_cnt_b;
   always @(posedge clk or negedge rst_b)
      if (!rst_b) re_cnt_b <= 0;
      else        re_cnt_b <= re_b ? re_cnt_b + 1 : 0;
   assign rdata_b = (re_b && re_cnt_b == 2) ? model(loc_b) : 32'hBAD0_BAD0;

   typedef struct {
      logic        ls;
      logic [31:0] data;
   } exp_t;

   exp_t q_a[$], q_b[$];
   exp_t ea, eb;
   int   errs = 0, checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (if_rvalid_a || ls_rvalid_a) begin
         chk("a_rvalid_onehot", {31'b0, if_rvalid_a & ls_rvalid_a}, 32'h0);
         if (q_a.size() == 0) begin
            checks++; errs++;
            $display("FAIL a_unexpected_rvalid: got if=%b ls=%b expected none", if_rvalid_a, ls_rvalid_a);
         end else begin
            ea = q_a.pop_front();
            chk("a_rvalid_port", {31'b0, ls_rvalid_a}, {31'b0, ea.ls});
            chk("a_rdata", ea.ls ? ls_rdata_a : if_rdata_a, ea.data);
         end
      end
      chk("a_ram_re_we_excl", {31'b0, re_a & we_a}, 32'h0);
   end

   always @(negedge clk) begin
      if (if_rvalid_b || ls_rvalid_b) begin
         chk("b_rvalid_onehot", {31'b0, if_rvalid_b & ls_rvalid_b}, 32'h0);
         if (q_b.size() == 0) begin
            checks++; errs++;
            $display("FAIL b_unexpected_rvalid: got if=%b ls=%b expected none", if_rvalid_b, ls_rvalid_b);
         end else begin
            eb = q_b.pop_front();
            chk("b_rvalid_port", {31'b0, ls_rvalid_b}, {31'b0, eb.ls});
            chk("b_rdata", eb.ls ? ls_rdata_b : if_rdata_b, eb.data);
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic exp_ls[6];

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      {if_req_a, ls_req_a, ls_we_a} = '0; {if_addr_a, ls_addr_a, ls_wdata_a} = '0;
      {if_req_b, ls_req_b, ls_we_b} = '0; {if_addr_b, ls_addr_b, ls_wdata_b} = '0;
      #1;
      chk("a_reset_ctrl", {26'b0, re_a, we_a, if_gnt_a, ls_gnt_a, if_rvalid_a, ls_rvalid_a}, 32'h0);
      chk("a_reset_loc", loc_a, 32'h0);
      chk("b_reset_ctrl", {26'b0, re_b, we_b, if_gnt_b, ls_gnt_b, if_rvalid_b, ls_rvalid_b}, 32'h0);
      cyc(2);
      rst_a = 1'b1; rst_b = 1'b1;
      cyc();

      // 1: single IF read, RAM_LAT=1
      if_req_a = 1'b1; if_addr_a = 32'h10;
      q_a.push_back('{1'b0, 32'h0050_0093});
      #1;
      chk("t1_stall_c0", {31'b0, stall_if_a}, 32'h1);
      chk("t1_gnt_c0", {31'b0, if_gnt_a}, 32'h0);
      cyc();
      chk("t1_gnt_re", {30'b0, if_gnt_a, re_a}, 32'h3);
      chk("t1_loc", loc_a, 32'h10);
      chk("t1_stall_c1", {31'b0, stall_if_a}, 32'h1);
      cyc();
      chk("t1_rvalid", {31'b0, if_rvalid_a}, 32'h1);
      chk("t1_stall_c2", {31'b0, stall_if_a}, 32'h0);
      if_req_a = 1'b0;
      cyc();

      // 2: simultaneous LS store and IF read
      ls_req_a = 1'b1; ls_we_a = 1'b1; ls_addr_a = 32'h100; ls_wdata_a = 32'hDEAD_BEEF;
      if_req_a = 1'b1; if_addr_a = 32'h14;
      q_a.push_back('{1'b1, 32'h0});
      q_a.push_back('{1'b0, 32'h1234_5678});
      cyc();
      chk("t2_gnts", {30'b0, ls_gnt_a, if_gnt_a}, 32'h2);
      chk("t2_we_re", {30'b0, we_a, re_a}, 32'h2);
      chk("t2_loc", loc_a, 32'h100);
      chk("t2_wdata", wdata_a, 32'hDEAD_BEEF);
      cyc();
      chk("t2_ls_rvalid", {31'b0, ls_rvalid_a}, 32'h1);
      chk("t2_stall_mem_c2", {31'b0, stall_mem_a}, 32'h0);
      ls_req_a = 1'b0; ls_we_a = 1'b0;
      cyc();
      chk("t2_if_wait", {31'b0, if_gnt_a}, 32'h0);
      cyc();
      chk("t2_if_gnt", {31'b0, if_gnt_a}, 32'h1);
      chk("t2_if_loc", loc_a, 32'h14);
      cyc();
      chk("t2_if_rvalid", {31'b0, if_rvalid_a}, 32'h1);
      if_req_a = 1'b0;
      cyc();

      // 3: both held: LS x4, IF, LS
      exp_ls = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      if_req_a = 1'b1; if_addr_a = 32'h14;
      ls_req_a = 1'b1; ls_we_a = 1'b0; ls_addr_a = 32'h300;
      for (int i = 0; i < 6; i++)
         q_a.push_back(exp_ls[i] ? '{1'b1, 32'hA5A5_0300} : '{1'b0, 32'h1234_5678});
      for (int i = 0; i < 6; i++) begin
         int n;
         n = 0;
         do begin
            cyc();
            n++;
         end while (!(if_gnt_a || ls_gnt_a) && n < 10);
         chk($sformatf("t3_winner%0d", i), {30'b0, ls_gnt_a, if_gnt_a}, exp_ls[i] ? 32'h2 : 32'h1);
         chk($sformatf("t3_gap%0d", i), n, (i == 0) ? 32'd1 : 32'd3);
      end
      if_req_a = 1'b0; ls_req_a = 1'b0;
      cyc(3);

      // 6: IF drops req mid-access; LS follows without extra delay
      if_req_a = 1'b1; if_addr_a = 32'h18;
      q_a.push_back('{1'b0, 32'hA5A5_0018});
      cyc();
      chk("t6_if_gnt", {31'b0, if_gnt_a}, 32'h1);
      if_req_a = 1'b0;
      ls_req_a = 1'b1; ls_we_a = 1'b0; ls_addr_a = 32'h40;
      q_a.push_back('{1'b1, 32'hA5A5_0040});
      cyc();
      chk("t6_if_rvalid", {31'b0, if_rvalid_a}, 32'h1);
      chk("t6_ls_gnt_c2", {31'b0, ls_gnt_a}, 32'h0);
      cyc();
      chk("t6_ls_gnt_c3", {31'b0, ls_gnt_a}, 32'h0);
      cyc();
      chk("t6_ls_gnt_c4", {31'b0, ls_gnt_a}, 32'h1);
      chk("t6_ls_loc", loc_a, 32'h40);
      cyc();
      chk("t6_ls_rvalid", {31'b0, ls_rvalid_a}, 32'h1);
      ls_req_a = 1'b0;
      cyc(2);

      // 4: LS load, RAM_LAT=3
      ls_req_b = 1'b1; ls_we_b = 1'b0; ls_addr_b = 32'h200;
      q_b.push_back('{1'b1, 32'hCAFE_F00D});
      cyc();
      chk("t4_gnt_re", {30'b0, ls_gnt_b, re_b}, 32'h3);
      chk("t4_loc_c1", loc_b, 32'h200);
      for (int k = 2; k <= 3; k++) begin
         cyc();
         chk($sformatf("t4_re_c%0d", k), {29'b0, re_b, ls_gnt_b, ls_rvalid_b}, 32'h4);
         chk($sformatf("t4_loc_c%0d", k), loc_b, 32'h200);
      end
      cyc();
      chk("t4_end", {30'b0, re_b, ls_rvalid_b}, 32'h1);
      ls_req_b = 1'b0;
      cyc();

      // 5: reset during 2nd ACCESS cycle of a store
      ls_req_b = 1'b1; ls_we_b = 1'b1; ls_addr_b = 32'h208; ls_wdata_b = 32'h1111_2222;
      cyc(2);
      chk("t5_we_before", {31'b0, we_b}, 32'h1);
      rst_b = 1'b0;
      #1;
      chk("t5_we_async", {31'b0, we_b}, 32'h0);
      chk("t5_loc_async", loc_b, 32'h0);
      chk("t5_rdata_cleared", ls_rdata_b, 32'h0);
      ls_req_b = 1'b0; ls_we_b = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("t5_no_rvalid", {31'b0, ls_rvalid_b}, 32'h0);
      end
      rst_b = 1'b1;
      cyc();
      if_req_b = 1'b1; if_addr_b = 32'h10;
      q_b.push_back('{1'b0, 32'h0050_0093});
      cyc();
      chk("t5_fresh_gnt", {31'b0, if_gnt_b}, 32'h1);
      cyc(3);
      chk("t5_fresh_rvalid", {31'b0, if_rvalid_b}, 32'h1);
      if_req_b = 1'b0;
      cyc(2);

      chk("a_queue_drained", q_a.size(), 32'h0);
      chk("b_queue_drained", q_b.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
